// File: rtl/gpu_uart_pkg.sv
// Shared UART definitions for the TX and RX sides of the host link.
package gpu_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned UART_DATA_BITS       = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO; dout always presents the head entry.
module byte_fifo
    import gpu_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic [CW-1:0]             count,
    output logic                      full,
    output logic                      empty
);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q;
    logic [AW-1:0]             rd_ptr_q;
    logic [CW-1:0]             count_q;
    logic                      do_push;
    logic                      do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Byte sink for command responses: ready/valid into a FIFO, then UART 8N1 out, LSB first.
module uart_tx_stream
    import gpu_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx,
    output logic                      tx_busy,
    output logic                      overflow
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IW = $clog2(UART_DATA_BITS);

    uart_state_e               state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [IW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      overflow_q, overflow_d;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             count_next;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      baud_done;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .rst   (rst),
        .push  (fifo_push),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready needs two free slots so a write issued one cycle after sampling it still fits.
    assign tx_ready   = (CW'(FIFO_DEPTH) - fifo_count) >= CW'(2);
    assign fifo_push  = tx_valid && !fifo_full;
    assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    assign baud_done  = (baud_q == BW'(CLKS_PER_BIT - 1));

    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign overflow = overflow_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                // Pop only from the registered count, so a byte pushed this cycle waits one cycle.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = TX_START;
                    tx_d     = 1'b0;
                end
            end
            TX_START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_DATA: begin
                tx_d = shift_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IW'(UART_DATA_BITS - 1)) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = TX_IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d     = (state_d != TX_IDLE) || (count_next != '0);
        overflow_d = overflow_q || (tx_valid && fifo_full);
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: frame-level reference model plus a line decoder.
module tb_uart_tx_stream;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of accepted bytes and a frame timer.
    logic [7:0] mq[$];
    logic [7:0] m_cur;
    bit         m_active  = 0;
    bit         m_ovf     = 0;
    bit         m_started = 0;
    int         m_t       = 0;
    bit         pop_now;
    bit         full_now;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_t      = 0;
            m_ovf    = 0;
        end else begin
            pop_now  = !m_active && (mq.size() != 0);
            full_now = (mq.size() == DEPTH);
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) m_active = 0;
            end else if (pop_now) begin
                m_cur    = mq.pop_front();
                m_active = 1;
                m_t      = 0;
            end
            if (tx_valid) begin
                if (full_now) m_ovf = 1;
                else          mq.push_back(tx_data);
            end
        end
        m_started = 1;
    end

    always @(negedge CLK) begin
        if (m_started) begin
            chk("tx_line", tx, m_active ? frame_bit(m_cur, m_t / CPB) : 1'b1);
            chk("tx_busy", tx_busy, m_active || (mq.size() != 0));
            chk("tx_ready", tx_ready, (DEPTH - mq.size()) >= 2);
            chk("overflow", overflow, m_ovf);
        end
    end

    // Line decoder: samples each bit in its middle and collects received bytes.
    logic [7:0] rxq[$];
    int         falls[$];
    logic [9:0] bits;
    logic [9:0] last_bits;
    logic       prev_tx = 1'b1;
    bit         rx_act  = 0;
    int         rx_cnt  = 0;

    always @(negedge CLK) begin
        if (rst) begin
            rx_act = 0;
        end else begin
            if (!rx_act && prev_tx === 1'b1 && tx === 1'b0) begin
                rx_act = 1;
                rx_cnt = 0;
                falls.push_back(cyc);
            end
            if (rx_act) begin
                if (rx_cnt % CPB == CPB / 2) bits[rx_cnt / CPB] = tx;
                if (rx_cnt == 9 * CPB + CPB / 2) begin
                    rx_act    = 0;
                    last_bits = bits;
                    rxq.push_back(bits[8:1]);
                    chk("stop_bit", bits[9], 1'b1);
                end
                rx_cnt++;
            end
        end
        prev_tx = tx;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge CLK);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        @(negedge CLK);
        while (tx_busy !== 1'b0 && i < budget) begin
            @(negedge CLK);
            i++;
        end
        chk("idle_timeout", tx_busy, 1'b0);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_fall(input int budget);
        int i = 0;
        @(negedge CLK);
        while (falls.size() == 0 && i < budget) begin
            @(negedge CLK);
            i++;
        end
        chk("fall_timeout", falls.size() != 0, 1'b1);
    endtask

    task automatic chk_rx(input string name, input logic [7:0] exp[$]);
        chk({name, "_count"}, rxq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rxq.size(); i++)
            chk({name, "_byte"}, rxq[i], exp[i]);
    endtask

    initial begin
        logic [9:0] a5_bits;
        logic [7:0] exp_q[$];
        a5_bits = 10'b11_0100_1010;

        tick(3);
        rst = 1'b0;
        @(negedge CLK);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_ovf", overflow, 1'b0);
        chk("reset_ready", tx_ready, 1'b1);
        tick(1);

        // Single byte: latency, bit pattern and frame length.
        rxq.delete(); falls.delete();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge CLK);
        chk("t1_write_cycle_tx", tx, 1'b1);
        @(posedge CLK); #1;
        tx_valid = 1'b0;
        @(negedge CLK);
        chk("t1_push_cycle_tx", tx, 1'b1);
        @(negedge CLK);
        chk("t1_start_edge", tx, 1'b0);
        repeat (FRAME - 1) @(negedge CLK);
        chk("t1_last_stop_tx", tx, 1'b1);
        chk("t1_last_stop_busy", tx_busy, 1'b1);
        @(negedge CLK);
        chk("t1_after_frame_busy", tx_busy, 1'b0);
        chk("t1_bits", last_bits, a5_bits);
        exp_q = '{8'hA5};
        chk_rx("t1_rx", exp_q);
        tick(1);

        // Back-to-back: each START begins the cycle after the previous STOP ends.
        rxq.delete(); falls.delete();
        wr(8'h00); wr(8'hFF); wr(8'h3C);
        wait_idle(400);
        exp_q = '{8'h00, 8'hFF, 8'h3C};
        chk_rx("t2_rx", exp_q);
        chk("t2_falls", falls.size(), 3);
        if (falls.size() == 3) begin
            chk("t2_gap01", falls[1] - falls[0], FRAME + 1);
            chk("t2_gap12", falls[2] - falls[1], FRAME + 1);
        end

        // Producer pulses valid one cycle after seeing ready.
        rxq.delete(); falls.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            int guard = 0;
            @(negedge CLK);
            while (tx_ready !== 1'b1 && guard < 500) begin
                @(negedge CLK);
                guard++;
            end
            chk("t3_ready_timeout", tx_ready, 1'b1);
            @(posedge CLK); #1;
            wr(8'(8'h21 + 8'(i * 13)));
            exp_q.push_back(8'(8'h21 + 8'(i * 13)));
        end
        wait_idle(1000);
        chk_rx("t3_rx", exp_q);
        chk("t3_ovf", overflow, 1'b0);

        // Overflow: six consecutive writes, sixth dropped.
        rxq.delete(); falls.delete();
        for (int i = 0; i < 6; i++) wr(8'(8'h11 + i));
        @(negedge CLK);
        chk("t4_ovf_set", overflow, 1'b1);
        chk("t4_ready_low", tx_ready, 1'b0);
        wait_idle(600);
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        chk_rx("t4_rx", exp_q);
        chk("t4_ovf_sticky", overflow, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge CLK);
        chk("t4_ovf_cleared", overflow, 1'b0);
        tick(1);

        // Reset during data bit 3 with two bytes queued.
        rxq.delete(); falls.delete();
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        wait_fall(50);
        repeat (4 * CPB + 1) @(negedge CLK);
        rst = 1'b1;
        @(posedge CLK); #1;
        rst = 1'b0;
        @(negedge CLK);
        chk("t5_tx", tx, 1'b1);
        chk("t5_busy", tx_busy, 1'b0);
        chk("t5_ready", tx_ready, 1'b1);
        chk("t5_ovf", overflow, 1'b0);
        repeat (3 * FRAME) @(negedge CLK);
        chk("t5_no_frames", rxq.size(), 0);
        chk("t5_idle_tx", tx, 1'b1);
        tick(1);

        // Push on the very cycle the FIFO head is popped.
        rxq.delete(); falls.delete();
        wr(8'hC1); wr(8'hC2);
        wait_fall(50);
        repeat (FRAME) @(posedge CLK);
        #1;
        wr(8'hC3);
        @(negedge CLK);
        chk("t6_second_start", tx, 1'b0);
        chk("t6_ready", tx_ready, 1'b1);
        wait_idle(400);
        exp_q = '{8'hC1, 8'hC2, 8'hC3};
        chk_rx("t6_rx", exp_q);
        chk("t6_falls", falls.size(), 3);
        if (falls.size() == 3) chk("t6_gap", falls[2] - falls[1], FRAME + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
